// File: rtl/usb_clk_rst_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_clk_rst_if
// Purpose  : Bundles the lock/reset-request inputs and the clock-enable/reset
//            outputs of the 48 MHz USB clock/reset manager.
// Signals  : pll_lock        - raw PLL lock (asynchronous to clk)
//            soft_reset_req  - level request to re-run the reset hold
//            ce[NUM_CE]      - one-cycle clock-enable strobes
//            sys_reset       - active-high reset to downstream logic
//            ready           - high while the manager is in RUN
//            lock_loss_count - saturating count of lock losses
// Modports : master - the clock/reset manager
//            slave  - the PLL/bus side and downstream consumers
// Revision : 1.0 - initial release
// ============================================================================
interface usb_clk_rst_if #(
  parameter int NUM_CE = 2
);
  logic              pll_lock;
  logic              soft_reset_req;
  logic [NUM_CE-1:0] ce;
  logic              sys_reset;
  logic              ready;
  logic [7:0]        lock_loss_count;

  modport master (
    input  pll_lock,
    input  soft_reset_req,
    output ce,
    output sys_reset,
    output ready,
    output lock_loss_count
  );

  modport slave (
    output pll_lock,
    output soft_reset_req,
    input  ce,
    input  sys_reset,
    input  ready,
    input  lock_loss_count
  );
endinterface
`default_nettype wire

// File: rtl/usb_clk_rst_gen.sv
`default_nettype none
// ============================================================================
// Module   : usb_clk_rst_gen
// Purpose  : Clock-enable and reset manager for the 48 MHz USB domain.
//            Synchronises PLL lock, waits for it to be stable, holds
//            sys_reset for a fixed number of cycles, then runs. Produces
//            divide-by-2^(i+1) clock-enable strobes instead of derived clocks.
// Ports    : clk     - 48 MHz clock, sole clock
//            reset_n - asynchronous active-low reset
//            bus     - usb_clk_rst_if.master (pll_lock, soft_reset_req in;
//                      ce, sys_reset, ready, lock_loss_count out)
// Options  : define USB_CLK_RST_LOCK_LOSS_CNT_EN to build the 8-bit
//            saturating lock-loss counter; otherwise lock_loss_count = 0.
// Revision : 1.0 - initial release
// ============================================================================
module usb_clk_rst_gen #(
  parameter int NUM_CE             = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 16
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  usb_clk_rst_if.master bus
);

  // Counter widths sized to hold the terminal value even when it is 0.
  localparam int c_stable_w = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int c_hold_w   = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [c_stable_w-1:0] c_stable_last = c_stable_w'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_hold_w-1:0]   c_hold_last   = c_hold_w'(RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_STABLE    = 2'd1,
    S_HOLD      = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_lock_meta;
  logic                  r_lock_s;
  logic [c_stable_w-1:0] r_stable_cnt;
  logic [c_hold_w-1:0]   r_hold_cnt;
  logic [NUM_CE-1:0]     r_div_cnt;
  logic [NUM_CE-1:0]     r_ce;
  logic                  r_sys_reset;
  logic                  r_ready;
  logic [NUM_CE-1:0]     w_div_inc;

  assign w_div_inc = r_div_cnt + NUM_CE'(1);

  // ce[i] is the AND of div bits [i:0]: a running prefix-AND gives every
  // strobe at once, and makes each slower strobe coincide with the faster ones.
  function automatic logic [NUM_CE-1:0] ce_strobes(input logic [NUM_CE-1:0] d);
    logic [NUM_CE-1:0] s;
    logic              all_ones;
    all_ones = 1'b1;
    for (int i = 0; i < NUM_CE; i++) begin
      all_ones = all_ones & d[i];
      s[i]     = all_ones;
    end
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_meta  <= 1'b0;
      r_lock_s     <= 1'b0;
      r_state      <= S_WAIT_LOCK;
      r_stable_cnt <= '0;
      r_hold_cnt   <= '0;
      r_div_cnt    <= '0;
      r_ce         <= '0;
      r_sys_reset  <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      r_lock_meta <= bus.pll_lock;
      r_lock_s    <= r_lock_meta;
      case (r_state)
        S_WAIT_LOCK: begin
          if (r_lock_s) begin
            r_state      <= S_STABLE;
            r_stable_cnt <= '0;
          end
        end
        S_STABLE: begin
          if (!r_lock_s) begin
            r_state <= S_WAIT_LOCK;
          end else if (r_stable_cnt == c_stable_last) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
            r_div_cnt  <= '0;
          end else begin
            r_stable_cnt <= r_stable_cnt + c_stable_w'(1);
          end
        end
        S_HOLD: begin
          if (!r_lock_s) begin
            r_state <= S_WAIT_LOCK;
            r_ce    <= '0;
          end else begin
            // Dividers keep running through the hold so downstream logic
            // sees enables while in reset.
            r_div_cnt <= w_div_inc;
            r_ce      <= ce_strobes(w_div_inc);
            if (bus.soft_reset_req) begin
              r_hold_cnt <= '0;
            end else if (r_hold_cnt == c_hold_last) begin
              r_state     <= S_RUN;
              r_sys_reset <= 1'b0;
              r_ready     <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
            end
          end
        end
        S_RUN: begin
          if (!r_lock_s) begin
            r_state     <= S_WAIT_LOCK;
            r_ce        <= '0;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
          end else if (bus.soft_reset_req) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            r_div_cnt   <= '0;
            r_ce        <= '0;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
          end else begin
            r_div_cnt <= w_div_inc;
            r_ce      <= ce_strobes(w_div_inc);
          end
        end
        default: begin
          r_state     <= S_WAIT_LOCK;
          r_ce        <= '0;
          r_sys_reset <= 1'b1;
          r_ready     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ce        = r_ce;
  assign bus.sys_reset = r_sys_reset;
  assign bus.ready     = r_ready;

`ifdef USB_CLK_RST_LOCK_LOSS_CNT_EN
  // A lock loss is any exit to WAIT_LOCK, which only lock_s=0 can cause.
  logic       w_lock_drop;
  logic [7:0] r_lock_loss_cnt;

  assign w_lock_drop = !r_lock_s && (r_state != S_WAIT_LOCK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_loss_cnt <= 8'd0;
    end else if (w_lock_drop && (r_lock_loss_cnt != 8'hFF)) begin
      r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
    end
  end

  assign bus.lock_loss_count = r_lock_loss_cnt;
`else
  assign bus.lock_loss_count = 8'd0;
`endif

endmodule
`default_nettype wire
